handler_arbiter: RTL and testbench

Packet-level arbiter that merges up to 16 Active Message handler streams onto the single `axis_handler` input of the GAScore handler bank. Each source presents whole 64-bit AXI-Stream messages: a header beat followed by payload beats, terminated by `tlast`. The arbiter grants one source per message, holds the grant until `tlast` is accepted, and rotates fairly between sources. It sits between the handler-producing stages (remote RX path, local loopback) and the per-kernel handler wrapper.

---
 rtl/handler_arbiter.sv | 115 +++++++++++
 tb/tb_handler_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handler_arbiter.sv
// Packet-level arbiter merging NUM_SOURCES AXI-Stream handler streams onto one output.
// Default is round-robin; define HANDLER_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module handler_arbiter #(
  parameter int NUM_SOURCES = 2,
  parameter int DATA_WIDTH  = 64,
  parameter int ID_WIDTH    = $clog2(NUM_SOURCES)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SOURCES-1:0]            s_axis_tvalid,
  input  logic [NUM_SOURCES-1:0]            s_axis_tlast,
  output logic [NUM_SOURCES-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]             axis_handler_tdata,
  output logic                              axis_handler_tvalid,
  output logic                              axis_handler_tlast,
  input  logic                              axis_handler_tready,
  input  logic                              arb_enable,
  output logic                              grant_valid,
  output logic [ID_WIDTH-1:0]               grant_id
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0] winner;
  logic [DATA_WIDTH-1:0] src_data [NUM_SOURCES];

  for (genvar k = 0; k < NUM_SOURCES; k++) begin : g_unpack
    assign src_data[k] = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef HANDLER_ARB_FIXED_PRIO_EN
  // Scan downward so the lowest valid index is the last (winning) assignment.
  always_comb begin
    winner = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (s_axis_tvalid[i]) winner = ID_WIDTH'(i);
    end
  end
`else
  logic [ID_WIDTH-1:0] last_id_q, last_id_d;

  // Search starts just past the last winner, so it has lowest priority next time.
  always_comb begin
    logic                found;
    logic [ID_WIDTH-1:0] cand;
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NUM_SOURCES; i++) begin
      cand = ID_WIDTH'((int'(last_id_q) + i) % NUM_SOURCES);
      if (!found && s_axis_tvalid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end
`endif

  // NOTE: every output and next-state value gets a default before the case so no latch is inferred.
  always_comb begin
    state_d             = state_q;
    grant_id_d          = grant_id_q;
`ifndef HANDLER_ARB_FIXED_PRIO_EN
    last_id_d           = last_id_q;
`endif
    s_axis_tready       = '0;
    axis_handler_tdata  = '0;
    axis_handler_tvalid = 1'b0;
    axis_handler_tlast  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_enable && (|s_axis_tvalid)) begin
          state_d    = ST_BUSY;
          grant_id_d = winner;
`ifndef HANDLER_ARB_FIXED_PRIO_EN
          last_id_d  = winner;
`endif
        end
      end
      ST_BUSY: begin
        axis_handler_tdata        = src_data[grant_id_q];
        axis_handler_tvalid       = s_axis_tvalid[grant_id_q];
        axis_handler_tlast        = s_axis_tlast[grant_id_q];
        s_axis_tready[grant_id_q] = axis_handler_tready;
        if (s_axis_tvalid[grant_id_q] && axis_handler_tready && s_axis_tlast[grant_id_q]) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_id_q <= '0;
`ifndef HANDLER_ARB_FIXED_PRIO_EN
      last_id_q  <= ID_WIDTH'(NUM_SOURCES - 1);
`endif
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
`ifndef HANDLER_ARB_FIXED_PRIO_EN
      last_id_q  <= last_id_d;
`endif
    end
  end

  assign grant_valid = (state_q == ST_BUSY);
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_handler_arbiter.sv
// Self-checking bench for handler_arbiter with four sources; output beats and grants
// are checked against scoreboard queues filled when messages are queued at the sources.
module tb_handler_arbiter;
  localparam int NS = 4;
  localparam int DW = 64;
  localparam int IW = 2;

  typedef struct packed {logic [DW-1:0] data; logic last;} beat_t;
  typedef struct packed {logic [IW-1:0] src; logic [DW-1:0] data; logic last;} exp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic [NS*DW-1:0]  s_axis_tdata;
  logic [NS-1:0]     s_axis_tvalid;
  logic [NS-1:0]     s_axis_tlast;
  logic [NS-1:0]     s_axis_tready;
  logic [DW-1:0]     axis_handler_tdata;
  logic              axis_handler_tvalid;
  logic              axis_handler_tlast;
  logic              axis_handler_tready;
  logic              arb_enable;
  logic              grant_valid;
  logic [IW-1:0]     grant_id;

  beat_t             src_q [NS][$];
  exp_t              exp_beats [$];
  logic [IW-1:0]     exp_grants [$];
  int                n_cmp = 0;
  int                n_err = 0;

  handler_arbiter #(.NUM_SOURCES(NS), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .axis_handler_tdata(axis_handler_tdata), .axis_handler_tvalid(axis_handler_tvalid),
    .axis_handler_tlast(axis_handler_tlast), .axis_handler_tready(axis_handler_tready),
    .arb_enable(arb_enable), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  // Source driver: presents each queue head after the rising edge, pops on handshake.
  initial begin
    logic [NS-1:0] hs;
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    forever begin
      @(negedge clock); #2;
      hs = s_axis_tvalid & s_axis_tready;
      @(posedge clock); #1;
      for (int k = 0; k < NS; k++) begin
        if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0) begin
          s_axis_tdata[k*DW +: DW] = src_q[k][0].data;
          s_axis_tvalid[k]         = 1'b1;
          s_axis_tlast[k]          = src_q[k][0].last;
        end else begin
          s_axis_tdata[k*DW +: DW] = '0;
          s_axis_tvalid[k]         = 1'b0;
          s_axis_tlast[k]          = 1'b0;
        end
      end
    end
  end

  // Output monitor: every transfer and every new grant is matched against the scoreboard.
  initial begin
    logic prev_gv;
    exp_t e;
    prev_gv = 1'b0;
    forever begin
      @(negedge clock); #1;
      if (!reset) begin
        if (grant_valid && !prev_gv) begin
          n_cmp++;
          if (exp_grants.size() == 0) begin
            n_err++;
            $display("FAIL grant_order: got unexpected grant to %0d, expected none", grant_id);
          end else begin
            logic [IW-1:0] g;
            g = exp_grants.pop_front();
            if (grant_id !== g) begin
              n_err++;
              $display("FAIL grant_order: got %0d expected %0d", grant_id, g);
            end
          end
        end
        if (axis_handler_tvalid && axis_handler_tready) begin
          n_cmp++;
          if (exp_beats.size() == 0) begin
            n_err++;
            $display("FAIL beat: got extra beat %h, expected none", axis_handler_tdata);
          end else begin
            e = exp_beats.pop_front();
            if (axis_handler_tdata !== e.data || axis_handler_tlast !== e.last || grant_id !== e.src) begin
              n_err++;
              $display("FAIL beat: got src %0d data %h last %b expected src %0d data %h last %b",
                       grant_id, axis_handler_tdata, axis_handler_tlast, e.src, e.data, e.last);
            end
          end
        end
      end
      prev_gv = reset ? 1'b0 : grant_valid;
    end
  end

  task automatic push_beat(input int src, input logic [DW-1:0] data, input logic last);
    src_q[src].push_back('{data: data, last: last});
    exp_beats.push_back('{src: IW'(src), data: data, last: last});
  endtask

  task automatic push_msg(input int src, input int nbeats, input logic [DW-1:0] base);
    exp_grants.push_back(IW'(src));
    for (int b = 0; b < nbeats; b++) push_beat(src, base + DW'(b), b == nbeats - 1);
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if (grant_valid !== 1'b0 || grant_id !== '0) begin
      n_err++;
      $display("FAIL reset_grant: got valid %b id %0d expected 0 0", grant_valid, grant_id);
    end
    n_cmp++;
    if (s_axis_tready !== '0 || axis_handler_tvalid !== 1'b0 || axis_handler_tlast !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got tready %b tvalid %b tlast %b expected all 0",
               s_axis_tready, axis_handler_tvalid, axis_handler_tlast);
    end
    n_cmp++;
    if (axis_handler_tdata !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h expected 0", axis_handler_tdata);
    end
  endtask

  task automatic test_single_source;
    logic exp_busy;
    @(negedge clock);
    exp_grants.push_back(2'd0);
    push_beat(0, {16{4'h1}}, 1'b0);
    push_beat(0, {16{4'h2}}, 1'b0);
    push_beat(0, {16{4'h3}}, 1'b1);
    for (int p = 1; p <= 5; p++) begin
      @(negedge clock); #1;
      exp_busy = (p >= 2 && p <= 4);
      n_cmp++;
      if (grant_valid !== exp_busy || axis_handler_tvalid !== exp_busy || s_axis_tready[0] !== exp_busy) begin
        n_err++;
        $display("FAIL single_timing[%0d]: got gv %b tvalid %b tready0 %b expected %b",
                 p, grant_valid, axis_handler_tvalid, s_axis_tready[0], exp_busy);
      end
    end
    n_cmp++;
    if (grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL single_hold_id: got %0d expected 0", grant_id);
    end
  endtask

  task automatic test_contention;
    int busy_cnt;
    @(negedge clock);
`ifdef HANDLER_ARB_FIXED_PRIO_EN
    push_msg(0, 2, 64'hC000_0000_0000_0000);
    push_msg(0, 2, 64'hC000_0000_0000_0010);
    push_msg(1, 2, 64'hC100_0000_0000_0000);
    push_msg(2, 2, 64'hC200_0000_0000_0000);
    push_msg(3, 2, 64'hC300_0000_0000_0000);
`else
    push_msg(0, 2, 64'hC000_0000_0000_0000);
    push_msg(1, 2, 64'hC100_0000_0000_0000);
    push_msg(2, 2, 64'hC200_0000_0000_0000);
    push_msg(3, 2, 64'hC300_0000_0000_0000);
    push_msg(0, 2, 64'hC000_0000_0000_0010);
`endif
    busy_cnt = 0;
    for (int p = 1; p <= 16; p++) begin
      @(negedge clock); #1;
      if (grant_valid) busy_cnt++;
    end
    n_cmp++;
    if (busy_cnt !== 10 || grant_valid !== 1'b0) begin
      n_err++;
      $display("FAIL contention_cycles: got %0d busy cycles, gv %b expected 10 busy, gv 0", busy_cnt, grant_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] base;
    logic [DW-1:0] exp_data;
    base = 64'hB000_0000_0000_0000;
    @(negedge clock);
    axis_handler_tready = 1'b1;
    push_msg(2, 4, base);
    @(negedge clock); #1;
    n_cmp++;
    if (grant_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_latency: got gv %b expected 0", grant_valid);
    end
    for (int p = 0; p <= 6; p++) begin
      @(negedge clock);
      axis_handler_tready = (p % 2 == 0);
      #1;
      exp_data = base + DW'((p + 1) / 2);
      n_cmp++;
      if (grant_valid !== 1'b1 || s_axis_tready !== {1'b0, axis_handler_tready, 2'b00} ||
          axis_handler_tdata !== exp_data) begin
        n_err++;
        $display("FAIL bp_beat[%0d]: got gv %b tready %b data %h expected 1 %b %h", p, grant_valid,
                 s_axis_tready, axis_handler_tdata, {1'b0, axis_handler_tready, 2'b00}, exp_data);
      end
    end
    @(negedge clock);
    axis_handler_tready = 1'b1;
    #1;
    n_cmp++;
    if (grant_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_end: got gv %b expected 0", grant_valid);
    end
  endtask

  task automatic test_single_beat;
    int xfers;
    logic exp_gv;
    @(negedge clock);
    push_msg(1, 1, 64'h5111_0000_0000_0001);
    push_msg(2, 1, 64'h5222_0000_0000_0002);
    xfers = 0;
    for (int p = 1; p <= 5; p++) begin
      @(negedge clock); #1;
      exp_gv = (p == 2 || p == 4);
      if (axis_handler_tvalid && axis_handler_tready) xfers++;
      n_cmp++;
      if (grant_valid !== exp_gv) begin
        n_err++;
        $display("FAIL single_beat_gv[%0d]: got %b expected %b", p, grant_valid, exp_gv);
      end
    end
    n_cmp++;
    if (xfers !== 2 || grant_id !== 2'd2) begin
      n_err++;
      $display("FAIL single_beat_sum: got %0d transfers id %0d expected 2 transfers id 2", xfers, grant_id);
    end
  endtask

  task automatic test_arb_enable;
    logic exp_gv;
    @(negedge clock);
    arb_enable = 1'b1;
    push_msg(0, 4, 64'hE000_0000_0000_0000);
    for (int p = 1; p <= 11; p++) begin
      @(negedge clock);
      if (p == 3) begin
        arb_enable = 1'b0;
        push_msg(3, 1, 64'hE300_0000_0000_0000);
      end
      if (p == 9) arb_enable = 1'b1;
      #1;
      exp_gv = (p >= 2 && p <= 5) || (p == 10);
      n_cmp++;
      if (grant_valid !== exp_gv) begin
        n_err++;
        $display("FAIL arb_enable_gv[%0d]: got %b expected %b", p, grant_valid, exp_gv);
      end
      if (p == 10) begin
        n_cmp++;
        if (grant_id !== 2'd3) begin
          n_err++;
          $display("FAIL arb_enable_id: got %0d expected 3", grant_id);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    push_msg(0, 4, 64'hA000_0000_0000_0000);
    repeat (2) @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < NS; k++) src_q[k].delete();
    exp_beats.delete();
    @(negedge clock); #1;
    n_cmp++;
    if (grant_valid !== 1'b0 || grant_id !== '0 || s_axis_tready !== '0 || axis_handler_tvalid !== 1'b0 ||
        axis_handler_tlast !== 1'b0 || axis_handler_tdata !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got gv %b id %0d tready %b tvalid %b tlast %b data %h expected all 0",
               grant_valid, grant_id, s_axis_tready, axis_handler_tvalid, axis_handler_tlast, axis_handler_tdata);
    end
    reset = 1'b0;
    push_msg(0, 1, 64'hA0A0_0000_0000_0000);
    push_msg(1, 1, 64'hA1A1_0000_0000_0000);
    for (int p = 5; p <= 9; p++) begin
      @(negedge clock); #1;
      if (p == 6) begin
        n_cmp++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
          n_err++;
          $display("FAIL reset_mid_first_grant: got gv %b id %0d expected 1 0", grant_valid, grant_id);
        end
      end
    end
  endtask

  initial begin
    reset               = 1'b1;
    arb_enable          = 1'b1;
    axis_handler_tready = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_contention();
    test_single_source();
    test_backpressure();
    test_single_beat();
    test_arb_enable();
    test_reset_mid();
    repeat (2) @(negedge clock);
    #1;
    n_cmp++;
    if (exp_beats.size() != 0 || exp_grants.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d beats %0d grants left expected 0 0",
               exp_beats.size(), exp_grants.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
